// File: rtl/prio_encoder_rr_pkg.sv
// Shared types for the registered priority encoder family.
package enc_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } enc_mode_e;

endpackage : enc_pkg

// File: rtl/prio_pick.sv
// Combinational circular priority search: first set bit found walking from
// `start` in the selected direction, wrapping at N.
module prio_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    input  logic         dir_up,
    output logic [W-1:0] idx,
    output logic         found
);

    int pos_s;

    // Scan offsets from far to near so the nearest set bit is the last writer.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos_s = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (dir_up) begin
                pos_s = int'(start) + i;
                if (pos_s >= N) begin
                    pos_s = pos_s - N;
                end else begin
                    pos_s = pos_s;
                end
            end else begin
                pos_s = int'(start) - i;
                if (pos_s < 0) begin
                    pos_s = pos_s + N;
                end else begin
                    pos_s = pos_s;
                end
            end
            if (vec[pos_s]) begin
                idx   = W'(pos_s);
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
    end

endmodule : prio_pick

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin
// arbitration, zero/multi-hot flags and valid/ready on both sides.
module prio_encoder_rr
    import enc_pkg::*;
#(
    parameter  int N         = 8,
    parameter  int LSB_FIRST = 1,
    localparam int W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    output logic [W-1:0] out,
    output logic         out_none,
    output logic         out_multi,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [W-1:0] FIX_START = (LSB_FIRST != 0) ? W'(0) : W'(N - 1);
    localparam logic         FIX_UP    = (LSB_FIRST != 0) ? 1'b1 : 1'b0;

    logic [W-1:0] out_q, out_d;
    logic         out_none_q, out_none_d;
    logic         out_multi_q, out_multi_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         accept_s, drain_s;
    logic [W-1:0] fix_idx_s, rr_idx_s, win_idx_s;
    logic         fix_found_s, rr_found_s, win_found_s;
    logic         seen_s, multi_s;

    prio_pick #(.N(N), .W(W)) u_pick_fixed (
        .vec    (in),
        .start  (FIX_START),
        .dir_up (FIX_UP),
        .idx    (fix_idx_s),
        .found  (fix_found_s)
    );

    prio_pick #(.N(N), .W(W)) u_pick_rr (
        .vec    (in),
        .start  (ptr_q),
        .dir_up (1'b1),
        .idx    (rr_idx_s),
        .found  (rr_found_s)
    );

    assign in_ready  = !out_valid_q || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign drain_s   = out_valid_q && out_ready;
    assign out       = out_q;
    assign out_none  = out_none_q;
    assign out_multi = out_multi_q;
    assign out_valid = out_valid_q;

    // Multi-hot detect: a set bit seen after another set bit.
    always_comb begin
        seen_s  = 1'b0;
        multi_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            multi_s = multi_s | (seen_s & in[i]);
            seen_s  = seen_s | in[i];
        end
    end

    // Next-state for result register and round-robin pointer.
    always_comb begin
        out_d       = out_q;
        out_none_d  = out_none_q;
        out_multi_d = out_multi_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        win_idx_s   = fix_idx_s;
        win_found_s = fix_found_s;
        if (accept_s) begin
            if (enc_mode_e'(mode) == MODE_RR) begin
                win_idx_s   = rr_idx_s;
                win_found_s = rr_found_s;
                if (rr_found_s) begin
                    // Wrap at N so non-power-of-2 sizes never point past the top.
                    ptr_d = (rr_idx_s == W'(N - 1)) ? W'(0) : rr_idx_s + W'(1);
                end else begin
                    ptr_d = ptr_q;
                end
            end else begin
                win_idx_s   = fix_idx_s;
                win_found_s = fix_found_s;
            end
            out_d       = win_found_s ? win_idx_s : W'(0);
            out_none_d  = !win_found_s;
            out_multi_d = multi_s;
            out_valid_d = 1'b1;
        end else if (drain_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_none_q  <= 1'b0;
            out_multi_q <= 1'b0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_none_q  <= out_none_d;
            out_multi_q <= out_multi_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule : prio_encoder_rr

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: an N=8 LSB-first instance and an N=5 instance.
module tb_prio_encoder_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // N = 8 instance
    logic       rst8_n;
    logic [7:0] in8;
    logic       in8_valid, in8_ready, mode8, out8_none, out8_multi, out8_valid, out8_ready;
    logic [2:0] out8;

    prio_encoder_rr #(.N(8), .LSB_FIRST(1)) dut8 (
        .clk(clk), .rst_n(rst8_n), .in(in8), .in_valid(in8_valid), .in_ready(in8_ready),
        .mode(mode8), .out(out8), .out_none(out8_none), .out_multi(out8_multi),
        .out_valid(out8_valid), .out_ready(out8_ready)
    );

    // N = 5 instance
    logic       rst5_n;
    logic [4:0] in5;
    logic       in5_valid, in5_ready, mode5, out5_none, out5_multi, out5_valid, out5_ready;
    logic [2:0] out5;

    prio_encoder_rr #(.N(5), .LSB_FIRST(1)) dut5 (
        .clk(clk), .rst_n(rst5_n), .in(in5), .in_valid(in5_valid), .in_ready(in5_ready),
        .mode(mode5), .out(out5), .out_none(out5_none), .out_multi(out5_multi),
        .out_valid(out5_valid), .out_ready(out5_ready)
    );

    typedef struct {
        logic [7:0] vin;
        logic       mode;
        logic [2:0] exp_out;
        logic       exp_none;
        logic       exp_multi;
    } vec8_t;

    typedef struct {
        logic [4:0] vin;
        logic       mode;
        logic [2:0] exp_out;
        logic       exp_none;
    } vec5_t;

    vec8_t tab8[15];
    vec5_t tab5[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One accepted transfer on the N=8 instance with the consumer always ready.
    task automatic xfer8(input logic [7:0] v, input logic m);
        in8 = v; mode8 = m; in8_valid = 1'b1; out8_ready = 1'b1;
        @(posedge clk); #1;
        in8_valid = 1'b0; in8 = 8'bx; mode8 = 1'bx;
    endtask

    task automatic xfer5(input logic [4:0] v, input logic m);
        in5 = v; mode5 = m; in5_valid = 1'b1; out5_ready = 1'b1;
        @(posedge clk); #1;
        in5_valid = 1'b0; in5 = 5'bx; mode5 = 1'bx;
    endtask

    initial begin
        tab8[0]  = '{8'h01, 1'b0, 3'd0, 1'b0, 1'b0};
        tab8[1]  = '{8'h80, 1'b0, 3'd7, 1'b0, 1'b0};
        tab8[2]  = '{8'h24, 1'b0, 3'd2, 1'b0, 1'b1};
        tab8[3]  = '{8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
        tab8[4]  = '{8'h85, 1'b1, 3'd0, 1'b0, 1'b1};
        tab8[5]  = '{8'h85, 1'b1, 3'd2, 1'b0, 1'b1};
        tab8[6]  = '{8'h85, 1'b1, 3'd7, 1'b0, 1'b1};
        tab8[7]  = '{8'h85, 1'b1, 3'd0, 1'b0, 1'b1};
        tab8[8]  = '{8'h85, 1'b1, 3'd2, 1'b0, 1'b1};
        tab8[9]  = '{8'h00, 1'b1, 3'd0, 1'b1, 1'b0};
        tab8[10] = '{8'h85, 1'b1, 3'd7, 1'b0, 1'b1};
        tab8[11] = '{8'h10, 1'b1, 3'd4, 1'b0, 1'b0};
        tab8[12] = '{8'hE1, 1'b0, 3'd0, 1'b0, 1'b1};
        tab8[13] = '{8'hE1, 1'b1, 3'd5, 1'b0, 1'b1};
        tab8[14] = '{8'hE1, 1'b1, 3'd6, 1'b0, 1'b1};

        tab5[0] = '{5'b00000, 1'b1, 3'd0, 1'b1};
        tab5[1] = '{5'b10001, 1'b1, 3'd0, 1'b0};
        tab5[2] = '{5'b10001, 1'b1, 3'd4, 1'b0};
        tab5[3] = '{5'b10001, 1'b1, 3'd0, 1'b0};
        tab5[4] = '{5'b10001, 1'b1, 3'd4, 1'b0};

        rst8_n = 1'b0; rst5_n = 1'b0;
        in8 = 8'bx; in8_valid = 1'b0; mode8 = 1'bx; out8_ready = 1'b0;
        in5 = 5'bx; in5_valid = 1'b0; mode5 = 1'bx; out5_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out8_valid}, 32'd0);
        chk("rst_out", {29'd0, out8}, 32'd0);
        chk("rst_flags", {30'd0, out8_none, out8_multi}, 32'd0);
        chk("rst_in_ready", {31'd0, in8_ready}, 32'd1);
        rst8_n = 1'b1; rst5_n = 1'b1;

        // Table-driven sequence on N=8; round-robin rows depend on pointer history.
        for (int i = 0; i < 15; i++) begin
            xfer8(tab8[i].vin, tab8[i].mode);
            chk($sformatf("t8[%0d].valid", i), {31'd0, out8_valid}, 32'd1);
            chk($sformatf("t8[%0d].out", i), {29'd0, out8}, {29'd0, tab8[i].exp_out});
            chk($sformatf("t8[%0d].none", i), {31'd0, out8_none}, {31'd0, tab8[i].exp_none});
            chk($sformatf("t8[%0d].multi", i), {31'd0, out8_multi}, {31'd0, tab8[i].exp_multi});
        end

        for (int i = 0; i < 5; i++) begin
            xfer5(tab5[i].vin, tab5[i].mode);
            chk($sformatf("t5[%0d].valid", i), {31'd0, out5_valid}, 32'd1);
            chk($sformatf("t5[%0d].out", i), {29'd0, out5}, {29'd0, tab5[i].exp_out});
            chk($sformatf("t5[%0d].none", i), {31'd0, out5_none}, {31'd0, tab5[i].exp_none});
        end

        // Backpressure: hold result 1 for three stalled cycles.
        in8 = 8'h02; mode8 = 1'b0; in8_valid = 1'b1; out8_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp_first_out", {29'd0, out8}, 32'd1);
        in8 = 8'h04;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_in_ready[%0d]", i), {31'd0, in8_ready}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("bp_out_stable[%0d]", i), {29'd0, out8}, 32'd1);
            chk($sformatf("bp_valid_stable[%0d]", i), {31'd0, out8_valid}, 32'd1);
        end
        out8_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in8_ready}, 32'd1);
        @(posedge clk); #1;
        chk("b2b_out0", {29'd0, out8}, 32'd2);
        chk("b2b_valid0", {31'd0, out8_valid}, 32'd1);
        in8 = 8'h08;
        @(posedge clk); #1;
        chk("b2b_out1", {29'd0, out8}, 32'd3);
        chk("b2b_valid1", {31'd0, out8_valid}, 32'd1);
        in8_valid = 1'b0; in8 = 8'bx; mode8 = 1'bx;
        @(posedge clk); #1;
        chk("drain_valid", {31'd0, out8_valid}, 32'd0);
        chk("drain_out_hold", {29'd0, out8}, 32'd3);

        // Async reset mid-operation with ptr = 3 and a held result.
        xfer8(8'hFF, 1'b0);
        xfer8(8'h04, 1'b1);
        out8_ready = 1'b0;
        chk("pre_rst_out", {29'd0, out8}, 32'd2);
        #2 rst8_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out8_valid}, 32'd0);
        chk("async_rst_out", {29'd0, out8}, 32'd0);
        #2 rst8_n = 1'b1;
        @(posedge clk); #1;
        xfer8(8'hFF, 1'b1);
        chk("post_rst_rr_out", {29'd0, out8}, 32'd0);
        chk("post_rst_rr_valid", {31'd0, out8_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_prio_encoder_rr
